bsg_cgol_readout: RTL
=====================

BSG_CGOL_READOUT -- requirements
Module: bsg_cgol_readout

Interface
REQ-001 SHALL have parameter board_width_p, default 8: cells per row and number of rows (square board), at least 2.
REQ-002 SHALL have port clk_i, input, 1: sole clock, all state changes on rising edge.
REQ-003 SHALL have port reset_i, input, 1: reset, synchronous and active-high.
REQ-004 SHALL have port board_i, input, board_width_p*board_width_p: board snapshot source; row r at bits [r*board_width_p +: board_width_p], 1 = alive.
REQ-005 SHALL have port capture_i, input, 1: request to snapshot board_i and start streaming.
REQ-006 SHALL have port ready_o, output, 1: high when idle and able to accept capture_i.
REQ-007 SHALL have port data_o, output, board_width_p: current row being offered.
REQ-008 SHALL have port v_o, output, 1: data_o valid.
REQ-009 SHALL have port last_o, output, 1: high with v_o when data_o is the final row.
REQ-010 SHALL have port yumi_i, input, 1: consumer takes the current row this cycle; legal only while v_o=1.

Function
REQ-011 SHALL implement two states, eIdle and eBusy; ready_o=1 exactly in eIdle, v_o=1 exactly in eBusy.
REQ-012 SHALL, in eIdle with capture_i=1, register board_i into an internal snapshot, clear the row counter to 0 and enter eBusy on the next edge.
REQ-013 SHALL present row 0 with v_o=1 in the cycle after capture acceptance (1-cycle latency).
REQ-014 SHALL drive data_o from the registered snapshot only; board_i changes after capture SHALL NOT affect output.
REQ-015 SHALL hold data_o, v_o, last_o stable while v_o=1 and yumi_i=0 (unlimited back-pressure).
REQ-016 SHALL, on yumi_i=1 in eBusy, advance the row counter by 1 so the next row appears the following cycle.
REQ-017 SHALL assert last_o when the row counter equals board_width_p-1.
REQ-018 SHALL, on yumi_i=1 with last_o=1, return to eIdle; ready_o=1 in the next cycle; a new capture SHALL NOT be accepted in the same cycle as the final yumi_i.
REQ-019 SHALL ignore capture_i while in eBusy; the snapshot and counter are unaffected.
REQ-020 SHALL ignore yumi_i while v_o=0.
REQ-021 SHALL size the row counter to $clog2(board_width_p) bits; it never wraps past board_width_p-1.
REQ-022 SHALL drive data_o to 0 while in eIdle.

Reset
REQ-023 SHALL, with reset_i=1 at an edge, enter eIdle, clear the counter and snapshot, and drive ready_o=1, v_o=0, last_o=0, data_o=0 from the next cycle.
REQ-024 SHALL abandon an in-progress stream on reset with no further rows emitted; reset SHALL take priority over capture_i and yumi_i in the same cycle.

Configuration
REQ-025 SHALL support macro BSG_CGOL_READOUT_ALIVE_COUNT_EN.
REQ-026 SHALL, when the macro is defined, add output alive_cnt_o, width $clog2(board_width_p+1): popcount of data_o, valid with v_o and 0 otherwise.
REQ-027 SHALL, when the macro is undefined, omit alive_cnt_o and all counting logic; other behaviour is identical.

Structure
REQ-028 SHALL take its state enum typedef (eIdle, eBusy) from shared package bsg_cgol_pkg.
REQ-029 SHALL use bsg_popcount as its single sub-module, instantiated only under BSG_CGOL_READOUT_ALIVE_COUNT_EN.

Verification (board_width_p=4)
REQ-030 SHALL cover: capture board_i=16'hA5C3 with yumi_i held at 1 -> rows 4'h3, 4'hC, 4'h5, 4'hA on four consecutive cycles; last_o only on 4'hA; ready_o=1 on the following cycle.
REQ-031 SHALL cover: yumi_i held at 0 for 5 cycles on row 1 -> data_o steady at row 1, v_o=1 throughout, counter unchanged.
REQ-032 SHALL cover: board_i changes and capture_i pulses during eBusy -> output rows still match the original snapshot.
REQ-033 SHALL cover: reset_i during row 2 -> next cycle v_o=0, ready_o=1, data_o=0; a new capture streams from row 0.
REQ-034 SHALL cover: capture_i=1 in the same cycle as the final yumi_i -> capture ignored; re-issuing capture_i in the next cycle is accepted.
REQ-035 SHALL cover: with BSG_CGOL_READOUT_ALIVE_COUNT_EN defined and row 4'hB -> alive_cnt_o=3; with v_o=0 -> alive_cnt_o=0.

Source files
------------

// File: rtl/bsg_cgol_pkg.sv
// Shared types for the Game-of-Life readout blocks.
package bsg_cgol_pkg;

    // Readout streaming state: waiting for a capture, or offering rows.
    typedef enum logic [0:0] {
        eIdle = 1'b0,
        eBusy = 1'b1
    } bsg_cgol_state_e;

endpackage

// File: rtl/bsg_popcount.sv
// Combinational population count of a bit vector.
module bsg_popcount #(
    parameter int unsigned width_p = 8
) (
    input  logic [width_p-1:0]           i,
    output logic [$clog2(width_p+1)-1:0] o
);

    localparam int unsigned cnt_width_lp = $clog2(width_p + 1);

    // Sum the set bits of the input.
    always_comb begin
        o = '0;
        for (int k = 0; k < width_p; k++) begin
            o = o + cnt_width_lp'(i[k]);
        end
    end

endmodule

// File: rtl/bsg_cgol_readout.sv
// Snapshots a square Game-of-Life board and streams it out one row per
// valid/yumi handshake, row 0 first.
// Optional feature macro: BSG_CGOL_READOUT_ALIVE_COUNT_EN adds alive_cnt_o,
// the number of live cells in the row currently offered on data_o.
module bsg_cgol_readout
    import bsg_cgol_pkg::*;
#(
    parameter int unsigned board_width_p = 8
) (
    input  logic                                   clk_i,
    input  logic                                   reset_i,
    input  logic [board_width_p*board_width_p-1:0] board_i,
    input  logic                                   capture_i,
    output logic                                   ready_o,
    output logic [board_width_p-1:0]               data_o,
    output logic                                   v_o,
    output logic                                   last_o,
    input  logic                                   yumi_i
`ifdef BSG_CGOL_READOUT_ALIVE_COUNT_EN
    ,
    output logic [$clog2(board_width_p+1)-1:0]     alive_cnt_o
`endif
);

    localparam int unsigned cnt_width_lp = $clog2(board_width_p);
    localparam logic [cnt_width_lp-1:0] last_row_lp = cnt_width_lp'(board_width_p - 1);

    bsg_cgol_state_e state_r, state_n;

    logic [board_width_p-1:0][board_width_p-1:0] snap_r;
    logic [cnt_width_lp-1:0]                     row_cnt_r;

    logic capture_accept;
    logic at_last_row;
    logic row_taken;

    assign capture_accept = (state_r == eIdle) && capture_i;
    assign at_last_row    = (row_cnt_r == last_row_lp);
    assign row_taken      = (state_r == eBusy) && yumi_i;

    // State register; reset wins over every other input.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_r <= eIdle;
        end else begin
            state_r <= state_n;
        end
    end

    // Next state: capture starts a stream, yumi on the final row ends it.
    always_comb begin
        state_n = state_r;
        unique case (state_r)
            eIdle: if (capture_i)              state_n = eBusy;
            eBusy: if (yumi_i && at_last_row)  state_n = eIdle;
            default:                           state_n = eIdle;
        endcase
    end

    // Snapshot and row counter; capture is only taken while idle.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            snap_r    <= '0;
            row_cnt_r <= '0;
        end else if (capture_accept) begin
            snap_r    <= board_i;
            row_cnt_r <= '0;
        end else if (row_taken && !at_last_row) begin
            row_cnt_r <= row_cnt_r + cnt_width_lp'(1);
        end
    end

    // Handshake and row outputs, all decoded from registered state.
    always_comb begin
        ready_o = 1'b0;
        v_o     = 1'b0;
        last_o  = 1'b0;
        data_o  = '0;
        if (state_r == eBusy) begin
            v_o    = 1'b1;
            last_o = at_last_row;
            data_o = snap_r[row_cnt_r];
        end else begin
            ready_o = 1'b1;
        end
    end

`ifdef BSG_CGOL_READOUT_ALIVE_COUNT_EN
    // data_o is zero while idle, so the count is zero whenever v_o is low.
    bsg_popcount #(
        .width_p (board_width_p)
    ) alive_count (
        .i (data_o),
        .o (alive_cnt_o)
    );
`else
    // No alive-count logic in this build.
`endif

endmodule
